// File: rtl/dcache_controller.sv
// ----------------------------------------------------------------------------
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between a CPU byte
//   port and a 32-bit block memory (6-bit block address, 4-byte blocks).
//   Hits complete without stalling; misses stall the CPU via busywait while
//   an optional write-back and then a refill run.
//
// Ports
//   clock, reset      : system clock, asynchronous active-low reset
//   read, write       : CPU request (exactly one high = valid request)
//   address           : CPU byte address {tag, index, offset}
//   writedata/readdata: CPU write / read byte
//   busywait          : CPU stall
//   mem_read/mem_write: block memory request (Moore outputs of the FSM)
//   mem_address       : block address
//   mem_writedata     : block to memory (byte0 = bits[7:0])
//   mem_readdata      : block from memory
//   mem_busywait      : memory access pending
// ----------------------------------------------------------------------------
module dcache_controller #(
    parameter int unsigned TAG_BITS   = 3,
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int unsigned NUM_LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic [31:0]          data_d [NUM_LINES];

    logic [TAG_BITS-1:0]   cpu_tag;
    logic [INDEX_BITS-1:0] cpu_index;
    logic [1:0]            cpu_offset;
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic                  cpu_req;
    logic                  hit;

    assign cpu_tag    = address[7 -: TAG_BITS];
    assign cpu_index  = address[2 +: INDEX_BITS];
    assign cpu_offset = address[1:0];

    // read && write together is not a request at all
    assign cpu_rd  = read & ~write;
    assign cpu_wr  = write & ~read;
    assign cpu_req = cpu_rd | cpu_wr;

    assign hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    // Outputs gated by reset so they read zero while reset is held.
    assign busywait = reset && cpu_req && !((state_q == IDLE) && hit);
    assign readdata = (reset && (state_q == IDLE) && cpu_rd && hit)
                    ? data_q[cpu_index][{cpu_offset, 3'b000} +: 8]
                    : '0;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req && !hit) begin
                    state_d = (valid_q[cpu_index] && dirty_q[cpu_index])
                            ? WRITEBACK : ALLOCATE;
                end else if (cpu_wr && hit) begin
                    data_d[cpu_index][{cpu_offset, 3'b000} +: 8] = writedata;
                    dirty_d[cpu_index] = 1'b1;
                end
            end
            WRITEBACK: begin
                mem_write     = reset;
                mem_address   = {tag_q[cpu_index], cpu_index};
                mem_writedata = data_q[cpu_index];
                if (!mem_busywait) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = reset;
                mem_address = {cpu_tag, cpu_index};
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // memory holds the fetched block through this cycle
                data_d[cpu_index]  = mem_readdata;
                tag_d[cpu_index]   = cpu_tag;
                valid_d[cpu_index] = 1'b1;
                dirty_d[cpu_index] = 1'b0;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents need no reset; valid bits qualify them.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_controller.sv
// ----------------------------------------------------------------------------
// tb_dcache_controller
//   Directed bench for dcache_controller. A latency-programmable block memory
//   answers the controller; a transaction-level cache model predicts every
//   output on every cycle; directed tests pin literal expectations.
// ----------------------------------------------------------------------------
module tb_dcache_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  writedata = '0;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_busywait = 1'b0;

    dcache_controller #(.TAG_BITS(3), .INDEX_BITS(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- block memory ----------------
    logic [31:0] bm [64];
    int unsigned lat = 2;
    int unsigned mem_cnt = 0;

    initial begin
        for (int i = 0; i < 64; i++) bm[i] = 32'hA5000000 | 32'(i * 257);
        bm[1]  = 32'h44332211;
        bm[9]  = 32'h88776655;
        bm[17] = 32'hCAFEF00D;
        forever begin
            @(negedge clock);
            if (!reset || !(mem_read || mem_write)) begin
                mem_cnt = 0;
                mem_busywait = 1'b0;
            end else if (mem_cnt < lat) begin
                mem_busywait = 1'b1;
                mem_cnt++;
            end else begin
                mem_busywait = 1'b0;
                mem_cnt = 0;
                if (mem_write) bm[mem_address] = mem_writedata;
                else           mem_readdata = bm[mem_address];
            end
        end
    end

    // ---------------- cache model + per-cycle compare ----------------
    logic        mv [8];
    logic        md [8];
    logic [2:0]  mt [8];
    logic [31:0] mdat [8];
    int          step = 0;   // 0 none, 1 write-back, 2 refill, 3 install
    logic [31:0] fill = '0;

    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic [5:0]  rd_seen_addr = '0;
    logic [5:0]  wb_seen_addr = '0;
    logic [31:0] wb_seen_data = '0;

    initial begin
        logic       rq_rd, rq_wr, hit_m, bmem, e_busy;
        logic [2:0] idx, tg;
        logic [1:0] off;
        logic [7:0] e_rd, wd;
        forever begin
            @(negedge clock);
            #2;
            if (mem_read)  begin rd_cycles++; rd_seen_addr = mem_address; end
            if (mem_write) begin
                wr_cycles++;
                wb_seen_addr = mem_address;
                wb_seen_data = mem_writedata;
            end
            if (!reset) begin
                for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
                step = 0;
                chk("rst_busywait",  {31'b0, busywait},  32'd0);
                chk("rst_readdata",  {24'b0, readdata},  32'd0);
                chk("rst_mem_read",  {31'b0, mem_read},  32'd0);
                chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
                @(posedge clock);
            end else begin
                rq_rd = read && !write;
                rq_wr = write && !read;
                idx   = address[4:2];
                tg    = address[7:5];
                off   = address[1:0];
                wd    = writedata;
                bmem  = mem_busywait;
                hit_m = mv[idx] && (mt[idx] == tg);
                e_busy = (step != 0) || ((rq_rd || rq_wr) && !hit_m);
                e_rd  = (step == 0 && rq_rd && hit_m) ? 8'(mdat[idx] >> (8 * off)) : 8'h00;
                chk("busywait",  {31'b0, busywait},  {31'b0, e_busy});
                chk("readdata",  {24'b0, readdata},  {24'b0, e_rd});
                chk("mem_read",  {31'b0, mem_read},  {31'b0, step == 2});
                chk("mem_write", {31'b0, mem_write}, {31'b0, step == 1});
                if (step == 1) begin
                    chk("wb_addr", {26'b0, mem_address}, {26'b0, mt[idx], idx});
                    chk("wb_data", mem_writedata, mdat[idx]);
                end
                if (step == 2) chk("rd_addr", {26'b0, mem_address}, {26'b0, tg, idx});
                @(posedge clock);
                case (step)
                    0: begin
                        if ((rq_rd || rq_wr) && !hit_m) begin
                            step = (mv[idx] && md[idx]) ? 1 : 2;
                        end else if (rq_wr && hit_m) begin
                            mdat[idx] = (mdat[idx] & ~(32'hFF << (8 * off)))
                                      | (32'(wd) << (8 * off));
                            md[idx] = 1'b1;
                        end
                    end
                    1: if (!bmem) step = 2;
                    2: if (!bmem) begin fill = bm[{tg, idx}]; step = 3; end
                    default: begin
                        mv[idx] = 1'b1; md[idx] = 1'b0;
                        mt[idx] = tg;   mdat[idx] = fill;
                        step = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; holds the request until busywait is low, then
    // keeps it one more posedge (write commit) and drops it at the negedge.
    task automatic access(input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] wdat, output logic [7:0] rdat,
                          output int cyc);
        logic done;
        read = r; write = w; address = a; writedata = wdat;
        cyc = 0; rdat = '0; done = 1'b0;
        while (!done && cyc < 60) begin
            #3;
            cyc++;
            if (!busywait) begin rdat = readdata; done = 1'b1; end
            else @(negedge clock);
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL access_timeout: addr %h still busy after %0d cycles", a, cyc);
        end
        @(negedge clock);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic clr_mon();
        rd_cycles = 0; wr_cycles = 0;
    endtask

    initial begin
        logic [7:0] rdat;
        int cyc;
        bit seen;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rdat;
        int cyc;
        bit seen;

        read = 1'b1; address = 8'h05;   // request held during reset must not stall
        #3;
        chk("reset_busywait", {31'b0, busywait}, 32'd0);
        chk("reset_mem_read", {31'b0, mem_read}, 32'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1; read = 1'b0;

        // 1: clean miss
        lat = 2; clr_mon();
        access(1'b1, 1'b0, 8'h05, 8'h00, rdat, cyc);
        chk("t1_readdata", {24'b0, rdat}, 32'h22);
        chk("t1_cycles", cyc, 6);
        chk("t1_rd_addr", {26'b0, rd_seen_addr}, 32'd1);
        chk("t1_no_wb", wr_cycles, 0);

        // 2: read hit
        clr_mon();
        access(1'b1, 1'b0, 8'h04, 8'h00, rdat, cyc);
        chk("t2_readdata", {24'b0, rdat}, 32'h11);
        chk("t2_cycles", cyc, 1);
        chk("t2_no_mem", rd_cycles + wr_cycles, 0);

        // 3: write hit then read back
        clr_mon();
        access(1'b0, 1'b1, 8'h06, 8'hAA, rdat, cyc);
        chk("t3_wr_cycles", cyc, 1);
        access(1'b1, 1'b0, 8'h06, 8'h00, rdat, cyc);
        chk("t3_readback", {24'b0, rdat}, 32'hAA);
        chk("t3_no_mem", rd_cycles + wr_cycles, 0);
        chk("t3_model_line1", mdat[1], 32'h44AA2211);

        // 4: dirty conflict
        lat = 1; clr_mon();
        access(1'b1, 1'b0, 8'h26, 8'h00, rdat, cyc);
        chk("t4_readdata", {24'b0, rdat}, 32'h77);
        chk("t4_cycles", cyc, 7);
        chk("t4_wb_addr", {26'b0, wb_seen_addr}, 32'd1);
        chk("t4_wb_data", wb_seen_data, 32'h44AA2211);
        chk("t4_rd_addr", {26'b0, rd_seen_addr}, 32'd9);
        chk("t4_mem_block1", bm[1], 32'h44AA2211);
        chk("t4_model_line1", mdat[1], 32'h88776655);

        // 5: read && write on a missing address
        clr_mon();
        access(1'b1, 1'b1, 8'h80, 8'h5A, rdat, cyc);
        chk("t5_cycles", cyc, 1);
        chk("t5_readdata", {24'b0, rdat}, 32'h00);
        chk("t5_no_mem", rd_cycles + wr_cycles, 0);

        // 6: reset during refill
        lat = 2;
        read = 1'b1; address = 8'h44;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #3;
            if (mem_read) seen = 1'b1;
            else @(negedge clock);
        end
        chk("t6_reached_alloc", {31'b0, seen}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #3;
        chk("t6_mem_read_drop", {31'b0, mem_read}, 32'd0);
        chk("t6_busy_drop", {31'b0, busywait}, 32'd0);
        @(negedge clock);
        reset = 1'b1; read = 1'b0;
        clr_mon();
        access(1'b1, 1'b0, 8'h04, 8'h00, rdat, cyc);
        chk("t6_miss_cycles", cyc, 6);
        chk("t6_rd_addr", {26'b0, rd_seen_addr}, 32'd1);
        chk("t6_readdata", {24'b0, rdat}, 32'h11);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
